rv_muldiv: RTL and testbench
============================

// Module: rv_muldiv
// PURPOSE
//  Multi-cycle RV32M multiply/divide unit: companion to the single-cycle ALU on the execute stage.
//  Core issues one op with operands via start pulse; unit stalls the core with busy, returns rd with done.
//  Fixed-latency iterative engine (1 bit/cycle): shift-add multiply, restoring divide; signs fixed at end.
// PARAMETERS
//  XLEN      32   operand/result width (only 32 supported)
//  CNT_W     5    iteration counter width, log2(XLEN)
// PORTS
//  clk       in   1     single clock, all state on rising edge
//  rst       in   1     synchronous, active-high reset
//  start_in  in   1     issue strobe; sampled only when busy=0
//  op_in     in   3     funct3: 0 MUL,1 MULH,2 MULHSU,3 MULHU,4 DIV,5 DIVU,6 REM,7 REMU
//  rs1       in   32    operand A (dividend / multiplicand)
//  rs2       in   32    operand B (divisor / multiplier)
//  rd        out  32    result; valid when done=1, held until next accepted start
//  busy      out  1     1 from cycle after accept through the done cycle
//  done      out  1     1-cycle pulse, rd valid
// BEHAVIOUR
//  Reset: state=IDLE, rd=0, busy=0, done=0, counter=0; rst mid-op aborts, no done pulse.
//  FSM: IDLE -(start_in)-> CALC -(cnt==31)-> FIX -> DONE -> IDLE.
//   IDLE: latch op, |rs1|,|rs2| per signedness, result-sign flags; cnt=0.
//   CALC: exactly 32 cycles, one iteration each, cnt 0..31.
//   FIX : negate/select result, load rd.  DONE: done=1, busy=1; next cycle busy=0.
//  Latency: accept edge E -> done high in cycle after edge E+34; fixed for all ops incl. corner cases.
//  start_in while busy=1 ignored (no queueing). start_in in DONE cycle ignored; re-issue from IDLE.
//  Signedness: MUL/MULH/DIV/REM signed both; MULHSU rs1 signed, rs2 unsigned; MULHU/DIVU/REMU unsigned.
//  Multiply: 64-bit product of magnitudes, negated if sign(a)^sign(b); MUL->[31:0], MULH*->[63:32].
//  Divide: 32-bit quotient/remainder of magnitudes; quotient sign = sa^sb, remainder sign = sa.
//  Div by zero (rs2=0): DIV/DIVU -> 32'hFFFF_FFFF; REM/REMU -> rs1. No trap.
//  Overflow DIV 32'h8000_0000 / 32'hFFFF_FFFF -> 32'h8000_0000; REM -> 0.
//  Corner results forced in FIX from flags latched at accept; engine still runs full 32 cycles.
//  -2^31 magnitude = 32'h8000_0000 as unsigned; no width loss (internal 33/64-bit regs).
//  Operands may change after accept; only latched copies used.
// STRUCTURE
//  rv_defs.v: `MD_MUL..`MD_REMU (3-bit funct3 codes), state encodings `MD_IDLE/CALC/FIX/DONE.
//  Sub-module rv_muldiv_core: unsigned iterative engine (mode, a, b, step/load) -> 64-bit acc,
//   32-bit quotient/remainder; rv_muldiv owns FSM, sign handling, corner cases, handshake.
// TESTING
//  MUL 7 x -3 -> rd=32'hFFFF_FFEB, done 34 edges after accept, busy high throughout.
//  MULH 0x8000_0000 x 0x8000_0000 -> 0x4000_0000; MULHU 0xFFFF_FFFF^2 -> 0xFFFF_FFFE;
//   MULHSU -1 x 0xFFFF_FFFF -> 0xFFFF_FFFF.
//  DIV -7/2 -> 0xFFFF_FFFD, REM -7/2 -> 0xFFFF_FFFF; DIVU 100/7 -> 14, REMU -> 2.
//  DIV x/0 -> 0xFFFF_FFFF, REM 5/0 -> 5; DIV 0x8000_0000/-1 -> 0x8000_0000, REM -> 0.
//  start_in held high across whole op with changing rs1/rs2 -> one result only, from accept operands.
//  rst asserted at CALC cnt=10 -> next cycle busy=0, done=0, rd=0; fresh op then completes normally.

Source files
------------

// File: rtl/rv_muldiv_pkg.sv
// Shared constants, issue context and sign helpers for the RV32M multiply/divide unit.
package rv_muldiv_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 5;
  localparam int unsigned DW    = 2 * XLEN;

  // funct3 operation codes
  localparam logic [2:0] MD_MUL    = 3'd0;
  localparam logic [2:0] MD_MULH   = 3'd1;
  localparam logic [2:0] MD_MULHSU = 3'd2;
  localparam logic [2:0] MD_MULHU  = 3'd3;
  localparam logic [2:0] MD_DIV    = 3'd4;
  localparam logic [2:0] MD_DIVU   = 3'd5;
  localparam logic [2:0] MD_REM    = 3'd6;
  localparam logic [2:0] MD_REMU   = 3'd7;

  // FSM state encodings
  localparam logic [1:0] MD_IDLE = 2'd0;
  localparam logic [1:0] MD_CALC = 2'd1;
  localparam logic [1:0] MD_FIX  = 2'd2;
  localparam logic [1:0] MD_DONE = 2'd3;

  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  // Everything about an accepted op that the final fix-up step needs
  typedef struct packed {
    logic [2:0]      op;
    logic            neg_a;
    logic            neg_res;
    logic            div_zero;
    logic            ovf;
    logic [XLEN-1:0] a_raw;
  } md_ctx_t;

  function automatic logic signed_a(input logic [2:0] op);
    return (op == MD_MUL) || (op == MD_MULH) || (op == MD_MULHSU) ||
           (op == MD_DIV) || (op == MD_REM);
  endfunction

  function automatic logic signed_b(input logic [2:0] op);
    return (op == MD_MUL) || (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
  endfunction

  function automatic logic [XLEN-1:0] neg_if(input logic neg, input logic [XLEN-1:0] x);
    return neg ? (~x + XLEN'(1)) : x;
  endfunction

endpackage

// File: rtl/rv_muldiv_if.sv
// Issue/result handshake between the execute stage and the multiply/divide unit.
interface rv_muldiv_if;
  logic                           start_in;
  logic [2:0]                     op_in;
  logic [rv_muldiv_pkg::XLEN-1:0] rs1;
  logic [rv_muldiv_pkg::XLEN-1:0] rs2;
  logic [rv_muldiv_pkg::XLEN-1:0] rd;
  logic                           busy;
  logic                           done;

  modport master (output start_in, op_in, rs1, rs2, input rd, busy, done);
  modport slave  (input start_in, op_in, rs1, rs2, output rd, busy, done);
endinterface

// File: rtl/rv_muldiv_core.sv
// Unsigned 1-bit/cycle engine: shift-add multiply or restoring divide on magnitudes.
module rv_muldiv_core
  import rv_muldiv_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            step,
  input  logic            mode_div,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [DW-1:0]   acc,
  output logic [XLEN-1:0] quo,
  output logic [XLEN-1:0] rem
);

  // hi: partial product / partial remainder; lo: multiplier / dividend turning into quotient
  logic [XLEN-1:0] hi, lo, b_q;
  logic [XLEN:0]   add_c, shl_c, sub_c;

  // One iteration of each algorithm; 33-bit sums keep carries and borrows
  always_comb begin
    add_c = {1'b0, hi} + (lo[0] ? {1'b0, b_q} : {(XLEN+1){1'b0}});
    shl_c = {hi, lo[XLEN-1]};
    sub_c = shl_c - {1'b0, b_q};
  end

  // Engine registers: load on issue, then one step per cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      hi  <= '0;
      lo  <= '0;
      b_q <= '0;
    end else if (load) begin
      hi  <= '0;
      lo  <= a;
      b_q <= b;
    end else if (step) begin
      if (mode_div) begin
        if (!sub_c[XLEN]) begin
          hi <= sub_c[XLEN-1:0];
          lo <= {lo[XLEN-2:0], 1'b1};
        end else begin
          hi <= shl_c[XLEN-1:0];
          lo <= {lo[XLEN-2:0], 1'b0};
        end
      end else begin
        hi <= add_c[XLEN:1];
        lo <= {add_c[0], lo[XLEN-1:1]};
      end
    end
  end

  assign acc = {hi, lo};
  assign quo = lo;
  assign rem = hi;

endmodule

// File: rtl/rv_muldiv.sv
// RV32M multiply/divide unit: issue handshake, FSM, sign handling and corner-case results.
module rv_muldiv
  import rv_muldiv_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  rv_muldiv_if.slave  bus
);

  logic [1:0]       state, state_next;
  logic [CNT_W-1:0] cnt;
  logic             busy_q, busy_next, done_q, done_next;
  logic             accept_c, na_c, nb_c;
  logic [XLEN-1:0]  mag_a_c, mag_b_c, res_c, rd_q, quo, rem;
  logic [DW-1:0]    acc, prod_c;
  md_ctx_t          ctx;

  // Operand magnitudes and sign flags, consumed only on the accept edge
  always_comb begin
    accept_c = (state == MD_IDLE) && !busy_q && bus.start_in;
    na_c     = signed_a(bus.op_in) && bus.rs1[XLEN-1];
    nb_c     = signed_b(bus.op_in) && bus.rs2[XLEN-1];
    mag_a_c  = neg_if(na_c, bus.rs1);
    mag_b_c  = neg_if(nb_c, bus.rs2);
  end

  rv_muldiv_core u_core (
    .clk      (clk),
    .rst      (rst),
    .load     (accept_c),
    .step     (state == MD_CALC),
    .mode_div (ctx.op[2]),
    .a        (mag_a_c),
    .b        (mag_b_c),
    .acc      (acc),
    .quo      (quo),
    .rem      (rem)
  );

  // State, iteration counter and registered handshake outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= MD_IDLE;
      cnt    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_next;
      busy_q <= busy_next;
      done_q <= done_next;
      cnt    <= (state == MD_CALC) ? cnt + CNT_W'(1) : '0;
    end
  end

  // Next state; done/busy are registered off DONE so the pulse lands one cycle after it
  always_comb begin
    state_next = state;
    busy_next  = busy_q;
    done_next  = 1'b0;
    case (state)
      MD_IDLE: begin
        busy_next = accept_c;
        if (accept_c) state_next = MD_CALC;
      end
      MD_CALC: begin
        busy_next = 1'b1;
        if (cnt == CNT_W'(XLEN - 1)) state_next = MD_FIX;
      end
      MD_FIX: begin
        busy_next  = 1'b1;
        state_next = MD_DONE;
      end
      MD_DONE: begin
        busy_next  = 1'b1;
        done_next  = 1'b1;
        state_next = MD_IDLE;
      end
      default: state_next = MD_IDLE;
    endcase
  end

  // Sign fix-up and forced corner results from flags captured at accept
  always_comb begin
    prod_c = ctx.neg_res ? (~acc + DW'(1)) : acc;
    res_c  = prod_c[XLEN-1:0];
    case (ctx.op)
      MD_MUL:                       res_c = prod_c[XLEN-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU: res_c = prod_c[DW-1:XLEN];
      MD_DIV, MD_DIVU:
        res_c = ctx.div_zero ? '1 : (ctx.ovf ? INT_MIN : neg_if(ctx.neg_res, quo));
      default:
        res_c = ctx.div_zero ? ctx.a_raw : (ctx.ovf ? '0 : neg_if(ctx.neg_a, rem));
    endcase
  end

  // Issue context latch and result register
  always_ff @(posedge clk) begin
    if (rst) begin
      ctx  <= '0;
      rd_q <= '0;
    end else begin
      if (accept_c) begin
        ctx.op       <= bus.op_in;
        ctx.neg_a    <= na_c;
        ctx.neg_res  <= na_c ^ nb_c;
        ctx.div_zero <= (bus.rs2 == '0);
        ctx.ovf      <= ((bus.op_in == MD_DIV) || (bus.op_in == MD_REM)) &&
                        (bus.rs1 == INT_MIN) && (bus.rs2 == '1);
        ctx.a_raw    <= bus.rs1;
      end
      if (state == MD_FIX) rd_q <= res_c;
    end
  end

  assign bus.rd   = rd_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_rv_muldiv.sv
// Self-checking bench for rv_muldiv: arithmetic reference model plus directed corner cases.
module tb_rv_muldiv;

  logic clk = 1'b0;
  logic rst;
  rv_muldiv_if bus();

  rv_muldiv dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference result straight from the RV32M definitions
  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [63:0] sa, sb, ua, ub, p;
    int ia, ib;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'd0, a};
    ub = {32'd0, b};
    ia = a;
    ib = b;
    case (op)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return 32'(ia / ib);
      end
      3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return 32'(ia % ib);
      end
      default: return (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", name, got, exp);
    end
  endtask

  // Cycle-level expectation: busy over [accept, accept+34] edges, done at accept+34
  int          edge_n = 0;
  logic        pend = 1'b0;
  int          acc_e = 0;
  logic [31:0] pend_res = '0;
  logic [31:0] last_rd = '0;

  always @(posedge clk) begin
    logic busy_prev, exp_busy, exp_done;
    edge_n++;
    if (rst) begin
      pend    = 1'b0;
      last_rd = '0;
    end else begin
      busy_prev = pend && (edge_n - 1 <= acc_e + 34);
      if (!busy_prev) pend = 1'b0;
      if (bus.start_in && !busy_prev) begin
        pend     = 1'b1;
        acc_e    = edge_n;
        pend_res = model(bus.op_in, bus.rs1, bus.rs2);
      end
    end
    exp_busy = pend && (edge_n <= acc_e + 34);
    exp_done = pend && (edge_n == acc_e + 34);
    if (exp_done) last_rd = pend_res;
    #1;
    chk("busy", 32'(bus.busy), 32'(exp_busy));
    chk("done", 32'(bus.done), 32'(exp_done));
    if (exp_done || !exp_busy) chk("rd", bus.rd, last_rd);
  end

  // Issue one op from idle and wait (bounded) for its done pulse
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output int lat);
    bit seen = 1'b0;
    res = 'x;
    lat = -1;
    @(negedge clk);
    bus.start_in = 1'b1;
    bus.op_in    = op;
    bus.rs1      = a;
    bus.rs2      = b;
    @(negedge clk);
    bus.start_in = 1'b0;
    bus.rs1      = $urandom;
    bus.rs2      = $urandom;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (bus.done) begin
        seen = 1'b1;
        res  = bus.rd;
        lat  = i;
      end else begin
        @(negedge clk);
      end
    end
    if (!seen) begin
      total++;
      bad++;
      $display("FAIL done_timeout: op=%0d no done within 40 cycles", op);
    end
    @(negedge clk);
  endtask

  logic [2:0]  v_op [14];
  logic [31:0] v_a [14];
  logic [31:0] v_b [14];
  logic [31:0] v_e [14];

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [31:0] res;
    int lat, ndone;
    logic [2:0] op;
    logic [31:0] a, b;

    v_op = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7, 3'd4, 3'd6, 3'd4, 3'd6, 3'd5, 3'd7};
    v_a  = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'hFFFF_FFF9,
             32'd100, 32'd100, 32'd12345, 32'd5, 32'h8000_0000, 32'h8000_0000, 32'd5, 32'd9};
    v_b  = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2, 32'd2,
             32'd7, 32'd7, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0};
    v_e  = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFD,
             32'hFFFF_FFFF, 32'd14, 32'd2, 32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0,
             32'hFFFF_FFFF, 32'd9};

    rst = 1'b1;
    bus.start_in = 1'b0;
    bus.op_in = '0;
    bus.rs1 = '0;
    bus.rs2 = '0;
    repeat (3) @(negedge clk);
    chk("reset_rd", bus.rd, 32'd0);
    chk("reset_busy", 32'(bus.busy), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Directed corner cases, model pinned to hand-computed values
    for (int k = 0; k < 14; k++) begin
      chk($sformatf("model_%0d", k), model(v_op[k], v_a[k], v_b[k]), v_e[k]);
      issue(v_op[k], v_a[k], v_b[k], res, lat);
      chk($sformatf("vec_%0d", k), res, v_e[k]);
      chk($sformatf("latency_%0d", k), 32'(lat), 32'd34);
    end

    // start_in held high with operands changing: exactly one result from accept operands
    ndone = 0;
    res = 'x;
    @(negedge clk);
    bus.start_in = 1'b1;
    bus.op_in = 3'd0;
    bus.rs1 = 32'd3;
    bus.rs2 = 32'd5;
    for (int i = 0; i < 35; i++) begin
      @(negedge clk);
      if (bus.done) begin
        ndone++;
        res = bus.rd;
      end
      bus.rs1 = $urandom;
      bus.rs2 = $urandom;
      bus.op_in = 3'($urandom_range(0, 7));
    end
    bus.start_in = 1'b0;
    chk("held_done_count", 32'(ndone), 32'd1);
    chk("held_result", res, 32'd15);
    repeat (2) @(negedge clk);

    // Reset in the middle of CALC (cnt=10) aborts with no done
    @(negedge clk);
    bus.start_in = 1'b1;
    bus.op_in = 3'd4;
    bus.rs1 = 32'd1000;
    bus.rs2 = 32'd3;
    @(negedge clk);
    bus.start_in = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_done", 32'(bus.done), 32'd0);
    chk("abort_rd", bus.rd, 32'd0);
    issue(3'd5, 32'd1000, 32'd33, res, lat);
    chk("after_abort", res, 32'd30);
    chk("after_abort_latency", 32'(lat), 32'd34);

    // Random ops with corner-biased operands
    for (int k = 0; k < 150; k++) begin
      op = 3'($urandom_range(0, 7));
      a  = pick();
      b  = pick();
      issue(op, a, b, res, lat);
      chk($sformatf("rand_op%0d_%h_%h", op, a, b), res, model(op, a, b));
    end

    // Random start strobes including while busy; the cycle checker judges acceptance
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      bus.start_in = ($urandom_range(0, 2) == 0);
      bus.op_in    = 3'($urandom_range(0, 7));
      bus.rs1      = pick();
      bus.rs2      = pick();
    end
    @(negedge clk);
    bus.start_in = 1'b0;
    repeat (40) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
